// File: rtl/id_operand_fetch_if.sv
// ---------------------------------------------------------------------------
// id_operand_fetch_if
//   Bundles every non-clock/reset signal of the operand-fetch stage:
//     - upstream decoded-instruction handshake (in_valid / in_ready + fields)
//     - register-file read ports (enables, addresses, returned data)
//     - EX / MEM forwarding sources
//     - downstream handshake toward EX (out_valid / out_ready + payload)
//     - flush request and load-use stall indication
//   Handshake rule, both sides: a transfer happens on a rising clock edge
//   where valid && ready are both high. The sender holds valid and payload
//   stable until that edge; ready may change freely.
//   modport slave  : the operand-fetch stage itself
//   modport master : the surrounding pipeline / register file / testbench
// ---------------------------------------------------------------------------
interface id_operand_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_pc;
    logic [ADDR_WIDTH-1:0] in_rs_addr;
    logic [ADDR_WIDTH-1:0] in_rt_addr;
    logic                  in_rs_use;
    logic                  in_rt_use;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [ADDR_WIDTH-1:0] in_dest_addr;
    logic                  in_dest_we;
    logic                  in_is_load;

    logic                  rf_read_en_1;
    logic                  rf_read_en_2;
    logic [ADDR_WIDTH-1:0] rf_read_addr_1;
    logic [ADDR_WIDTH-1:0] rf_read_addr_2;
    logic [DATA_WIDTH-1:0] rf_read_data_1;
    logic [DATA_WIDTH-1:0] rf_read_data_2;

    logic                  ex_we;
    logic                  ex_is_load;
    logic [ADDR_WIDTH-1:0] ex_addr;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_pc;
    logic [DATA_WIDTH-1:0] out_op_a;
    logic [DATA_WIDTH-1:0] out_op_b;
    logic [ADDR_WIDTH-1:0] out_dest_addr;
    logic                  out_dest_we;
    logic                  out_is_load;
    logic                  load_use_stall;

    modport slave (
        input  flush, in_valid, in_pc, in_rs_addr, in_rt_addr, in_rs_use, in_rt_use,
               in_imm, in_dest_addr, in_dest_we, in_is_load,
               rf_read_data_1, rf_read_data_2,
               ex_we, ex_is_load, ex_addr, ex_data, mem_we, mem_addr, mem_data,
               out_ready,
        output in_ready, rf_read_en_1, rf_read_en_2, rf_read_addr_1, rf_read_addr_2,
               out_valid, out_pc, out_op_a, out_op_b, out_dest_addr, out_dest_we,
               out_is_load, load_use_stall
    );

    modport master (
        output flush, in_valid, in_pc, in_rs_addr, in_rt_addr, in_rs_use, in_rt_use,
               in_imm, in_dest_addr, in_dest_we, in_is_load,
               rf_read_data_1, rf_read_data_2,
               ex_we, ex_is_load, ex_addr, ex_data, mem_we, mem_addr, mem_data,
               out_ready,
        input  in_ready, rf_read_en_1, rf_read_en_2, rf_read_addr_1, rf_read_addr_2,
               out_valid, out_pc, out_op_a, out_op_b, out_dest_addr, out_dest_we,
               out_is_load, load_use_stall
    );
endinterface

// File: rtl/id_operand_fetch.sv
// ---------------------------------------------------------------------------
// id_operand_fetch
//   Operand-fetch stage between decode and EX. Drives the two register-file
//   read ports combinationally, resolves each source operand with
//   r0 / EX / MEM / register-file priority, stalls on load-use and
//   registers the resolved instruction into a valid/ready slot toward EX.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - id_operand_fetch_if.slave (all handshake, RF and forwarding
//            signals; see the interface header)
//   The stage has no FSM; its only state is the output register.
// ---------------------------------------------------------------------------
module id_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    id_operand_fetch_if.slave  bus
);
    logic [DATA_WIDTH-1:0] w_rs_val;
    logic [DATA_WIDTH-1:0] w_rt_val;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic                  w_hazard;
    logic                  w_advance;
    logic                  w_in_ready;

    logic                  r_out_valid;
    logic [31:0]           r_out_pc;
    logic [DATA_WIDTH-1:0] r_out_op_a;
    logic [DATA_WIDTH-1:0] r_out_op_b;
    logic [ADDR_WIDTH-1:0] r_out_dest_addr;
    logic                  r_out_dest_we;
    logic                  r_out_is_load;

    assign bus.rf_read_en_1   = bus.in_valid && bus.in_rs_use;
    assign bus.rf_read_en_2   = bus.in_valid && bus.in_rt_use;
    assign bus.rf_read_addr_1 = bus.in_rs_addr;
    assign bus.rf_read_addr_2 = bus.in_rt_addr;

    // EX forwarding excludes loads: their data is not ready until MEM, which
    // is exactly the load-use case handled by the stall below.
    always_comb begin
        w_rs_val = bus.rf_read_data_1;
        if (bus.in_rs_addr == '0)
            w_rs_val = '0;
        else if (bus.ex_we && !bus.ex_is_load && (bus.ex_addr == bus.in_rs_addr))
            w_rs_val = bus.ex_data;
        else if (bus.mem_we && (bus.mem_addr == bus.in_rs_addr))
            w_rs_val = bus.mem_data;
    end

    always_comb begin
        w_rt_val = bus.rf_read_data_2;
        if (bus.in_rt_addr == '0)
            w_rt_val = '0;
        else if (bus.ex_we && !bus.ex_is_load && (bus.ex_addr == bus.in_rt_addr))
            w_rt_val = bus.ex_data;
        else if (bus.mem_we && (bus.mem_addr == bus.in_rt_addr))
            w_rt_val = bus.mem_data;
    end

    assign w_op_a = bus.in_rs_use ? w_rs_val : '0;
    assign w_op_b = bus.in_rt_use ? w_rt_val : bus.in_imm;

    // Unused sources never stall, and r0 never creates a dependency.
    assign w_hazard = bus.in_valid && bus.ex_we && bus.ex_is_load && (bus.ex_addr != '0) &&
                      ((bus.in_rs_use && (bus.in_rs_addr == bus.ex_addr)) ||
                       (bus.in_rt_use && (bus.in_rt_addr == bus.ex_addr)));

    assign w_advance  = !r_out_valid || bus.out_ready;
    // rst is folded in so nothing is reported as accepted during the reset cycle.
    assign w_in_ready = w_advance && !w_hazard && !bus.flush && !rst;

    assign bus.in_ready       = w_in_ready;
    assign bus.load_use_stall = w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= '0;
            r_out_op_a      <= '0;
            r_out_op_b      <= '0;
            r_out_dest_addr <= '0;
            r_out_dest_we   <= 1'b0;
            r_out_is_load   <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_advance) begin
            if (bus.in_valid && w_in_ready) begin
                r_out_valid     <= 1'b1;
                r_out_pc        <= bus.in_pc;
                r_out_op_a      <= w_op_a;
                r_out_op_b      <= w_op_b;
                r_out_dest_addr <= bus.in_dest_addr;
                r_out_dest_we   <= bus.in_dest_we;
                r_out_is_load   <= bus.in_is_load;
            end else begin
                // Bubble: payload is don't-care, so it is simply held.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_pc        = r_out_pc;
    assign bus.out_op_a      = r_out_op_a;
    assign bus.out_op_b      = r_out_op_b;
    assign bus.out_dest_addr = r_out_dest_addr;
    assign bus.out_dest_we   = r_out_dest_we;
    assign bus.out_is_load   = r_out_is_load;
endmodule

// File: doc/id_operand_fetch.md
# id_operand_fetch

Operand-fetch stage of the decode pipeline, sitting directly upstream of the register file and feeding the ID/EX boundary. It takes decoded register/immediate fields and drives the two register-file read ports. It resolves RAW hazards by forwarding from EX and MEM and by stalling one cycle on load-use. Resolved operands are registered into a valid/ready output toward EX.

## Interface
- DATA_WIDTH, 32, operand/data width
- ADDR_WIDTH, 5, register address width (32 GPRs, r0 hard-wired zero)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard output register and refuse input this cycle
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_pc  in  32  instruction PC
- in_rs_addr, in_rt_addr  in  ADDR_WIDTH  source registers
- in_rs_use, in_rt_use  in  1  source actually read
- in_imm  in  DATA_WIDTH  immediate, used as op_b when !in_rt_use
- in_dest_addr  in  ADDR_WIDTH  destination register
- in_dest_we  in  1  instruction writes dest
- in_is_load  in  1  instruction is a load
- rf_read_en_1, rf_read_en_2  out  1  register-file port enables
- rf_read_addr_1, rf_read_addr_2  out  ADDR_WIDTH  port addresses
- rf_read_data_1, rf_read_data_2  in  DATA_WIDTH  port data; the register file already bypasses same-cycle WB writes
- ex_we, ex_is_load  in  1  instruction currently in EX writes / is a load
- ex_addr  in  ADDR_WIDTH;  ex_data  in  DATA_WIDTH  EX result
- mem_we  in  1;  mem_addr  in  ADDR_WIDTH;  mem_data  in  DATA_WIDTH  MEM result, load data included
- out_valid  out  1;  out_ready  in  1  handshake to EX
- out_pc  out  32;  out_op_a, out_op_b  out  DATA_WIDTH
- out_dest_addr  out  ADDR_WIDTH;  out_dest_we, out_is_load  out  1
- load_use_stall  out  1  hazard stall asserted this cycle

## Operation
- Combinational read: rf_read_en_1 = in_valid && in_rs_use and rf_read_addr_1 = in_rs_addr. Port 2 is driven the same way from rt.
- Source value priority per operand: address 0 gives 0 and is never forwarded. Otherwise an EX match (ex_we && ex_addr==src && !ex_is_load) gives ex_data. Otherwise a MEM match (mem_we && mem_addr==src) gives mem_data. Otherwise the register-file data is used.
- out_op_a = resolved rs if in_rs_use, else 0.
- out_op_b = resolved rt if in_rt_use, else in_imm.
- Load-use hazard: in_valid && ex_we && ex_is_load && ex_addr!=0, and ex_addr matches a used source. load_use_stall is the same signal.
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush.
- Output register update, in priority order:
  - rst: clear everything.
  - flush: out_valid <= 0.
  - advance: load the resolved instruction if in_valid && in_ready. Otherwise insert a bubble (out_valid <= 0, payload don't-care but held).
  - else: hold all outputs.
- On a stall the input is not consumed; upstream holds it, and forwarding re-evaluates next cycle, normally by a MEM match.

## Timing
- Reset: out_valid=0 and out_pc/op_a/op_b/dest_addr/dest_we/is_load=0. in_ready is 0 during the rst cycle.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with no hazard and out_ready held high.
- Load-use costs exactly 1 bubble when the load advances EX→MEM the next cycle.
- Backpressure: with out_valid && !out_ready, outputs are stable and in_ready=0.
- Flush with a simultaneous hazard or backpressure: flush wins, and out_valid=0 next cycle.
- Reset asserted mid-stall clears state. The pending upstream instruction is re-presented by upstream.
- EX and MEM both matching the same source: EX data is used.

## Test plan
- Independent stream: r1=5, r2=7 in regfile, issue rs=1, rt=2 → next cycle out_valid=1, op_a=5, op_b=7, in_ready=1 every cycle.
- EX forward: ex_we=1, ex_addr=3, ex_data=0x11, mem_addr=3, mem_data=0x22, regfile r3=0x33, read rs=3 → op_a=0x11. Drop EX match → 0x22. Drop MEM match → 0x33.
- r0 guard: ex_we=1, ex_addr=0, ex_data=0xFF, read rs=0 → op_a=0, no stall even with ex_is_load=1.
- Load-use: ex_is_load=1, ex_addr=4, read rt=4 → load_use_stall=1, in_ready=0, out_valid=0 next cycle. Next cycle mem_addr=4, mem_data=0xAB → accepted, op_b=0xAB.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → outputs unchanged, in_ready=0. Release → next instruction accepted the same cycle.
- Flush + rst: flush during out_ready=0 → out_valid=0 next cycle. rst asserted while valid → all outputs 0 next cycle, in_ready=0 during the rst cycle.
